// File: rtl/ahb_mem_access_pkg.sv
// Shared AHB-Lite codes and FSM encoding for the memory access unit and the
// downstream extend stage.
package ahb_mem_access_pkg;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // A request is legal when the size is supported and naturally aligned.
  function automatic logic req_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_mem_access_lane_align.sv
// Byte-lane steering: replicates store data across the bus and picks the
// addressed lane(s) out of read data, zero-extended.
module ahb_lane_align
  import ahb_mem_access_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hrdata,
  output logic [31:0] o_hwdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_byte_shift;
  logic [15:0] w_half;

  assign w_byte_shift = i_hrdata >> {i_addr_lo, 3'b000};
  assign w_half       = i_addr_lo[1] ? i_hrdata[31:16] : i_hrdata[15:0];

  // Lane replication for writes and lane selection for reads, by size.
  always_comb begin
    o_hwdata = i_wdata;
    o_rdata  = i_hrdata;
    case (i_size)
      HSIZE_BYTE: begin
        o_hwdata = {4{i_wdata[7:0]}};
        o_rdata  = {24'h0, w_byte_shift[7:0]};
      end
      HSIZE_HALF: begin
        o_hwdata = {2{i_wdata[15:0]}};
        o_rdata  = {16'h0, w_half};
      end
      default: begin
        o_hwdata = i_wdata;
        o_rdata  = i_hrdata;
      end
    endcase
  end

endmodule

// File: rtl/ahb_mem_access.sv
// Single-outstanding AHB-Lite master for CPU loads/stores. Illegal (unaligned
// or oversize) requests complete with an error without touching the bus.
module ahb_mem_access
  import ahb_mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [2:0]  mem_size,
  input  logic [31:0] w_mem_data,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        mem_err,
  output logic [31:0] r_mem_data,
  output logic [2:0]  r_size,
  output logic [31:0] HADDR,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  state_e      r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_req_size;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [1:0]  r_htrans;
  logic        r_done;
  logic        r_err;

  logic        w_legal;
  logic        w_can_accept;
  logic [31:0] w_rdata;

  assign w_legal      = req_legal(mem_size, mem_addr[1:0]);
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_RESP);

  ahb_lane_align u_align (
    .i_size    (r_req_size),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_hrdata  (HRDATA),
    .o_hwdata  (HWDATA),
    .o_rdata   (w_rdata)
  );

  assign HADDR    = r_addr;
  assign HSIZE    = r_req_size;
  assign HWRITE   = r_write;
  assign HTRANS   = r_htrans;
  assign mem_done = r_done;
  assign mem_err  = r_err;

  // Busy covers the accept cycle so the pipeline stalls as soon as it issues.
  assign mem_busy = ~reset & ((r_state == ST_ADDR) || (r_state == ST_DATA) ||
                              (mem_req && w_can_accept));

  // Transfer FSM; all bus-facing controls are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_req_size <= HSIZE_BYTE;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_htrans   <= HTRANS_IDLE;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_mem_data <= '0;
      r_size     <= HSIZE_BYTE;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (mem_req) begin
            r_addr     <= mem_addr;
            r_req_size <= mem_size;
            r_write    <= mem_write;
            r_wdata    <= w_mem_data;
            if (w_legal) begin
              r_state  <= ST_ADDR;
              r_htrans <= HTRANS_NONSEQ;
            end else begin
              // No bus cycle: report the error straight away.
              r_state <= ST_RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            r_state  <= ST_DATA;
            r_htrans <= HTRANS_IDLE;
          end
        end
        ST_DATA: begin
          // An error response's first (HREADY=0) cycle just waits.
          if (HREADY) begin
            r_state <= ST_RESP;
            r_done  <= 1'b1;
            r_err   <= HRESP;
            if (!r_write && !HRESP) begin
              r_mem_data <= w_rdata;
              r_size     <= r_req_size;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mem_access.sv
// Self-checking bench: directed scenarios plus randomized transfers compared
// against a transaction-level model of the load/store unit.
module tb_ahb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_write;
  logic [31:0] mem_addr, w_mem_data;
  logic [2:0]  mem_size;
  logic        mem_busy, mem_done, mem_err;
  logic [31:0] r_mem_data;
  logic [2:0]  r_size;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;

  ahb_mem_access dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_size(mem_size), .w_mem_data(w_mem_data),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
    .r_mem_data(r_mem_data), .r_size(r_size),
    .HADDR(HADDR), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of the visible load result registers.
  logic [31:0] m_rdata = 32'h0;
  logic [2:0]  m_rsize = 3'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_legal(input logic [31:0] a, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b0;
    return (a % (32'd1 << sz)) == 0;
  endfunction

  function automatic logic [31:0] m_mask(input logic [2:0] sz);
    return (sz == 3'd0) ? 32'hFF : (sz == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] m_rep(input logic [31:0] wd, input logic [2:0] sz);
    if (sz == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [2:0] sz);
    int sh;
    sh = (sz == 3'd0) ? 8 * (a % 4) : (sz == 3'd1) ? 16 * ((a / 2) % 2) : 0;
    return (rd >> sh) & m_mask(sz);
  endfunction

  // Drives one request from the current (idle/resp) cycle through to its
  // completion cycle. wa/wd are address/data-phase wait states. With hold=1
  // mem_req stays high so the caller must chain the next transfer at once.
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wdat, input logic [31:0] rdat,
                         input int wa, input int wd, input bit rsp, input bit hold);
    bit legal;
    legal = m_legal(a, sz);
    mem_req = 1'b1; mem_write = wr; mem_addr = a; mem_size = sz; w_mem_data = wdat;
    HREADY = 1'b1; HRESP = 1'b0;
    #1;
    chk("busy_accept", mem_busy, 1'b1);
    nxt();
    mem_req = hold;
    #1;
    if (!legal) begin
      chk("illegal_htrans", HTRANS, 2'b00);
      chk("illegal_done", mem_done, 1'b1);
      chk("illegal_err", mem_err, 1'b1);
      chk("illegal_rdata", r_mem_data, m_rdata);
      chk("resp_busy", mem_busy, hold);
    end else begin
      chk("addr_htrans", HTRANS, 2'b10);
      chk("addr_haddr", HADDR, a);
      chk("addr_hsize", HSIZE, sz);
      chk("addr_hwrite", HWRITE, wr);
      chk("addr_done", mem_done, 1'b0);
      for (int i = 0; i < wa; i++) begin
        HREADY = 1'b0;
        nxt(); #1;
        chk("addr_stall_htrans", HTRANS, 2'b10);
        chk("addr_stall_haddr", HADDR, a);
      end
      HREADY = 1'b1;
      nxt(); #1;
      chk("data_htrans", HTRANS, 2'b00);
      chk("data_busy", mem_busy, 1'b1);
      chk("data_done", mem_done, 1'b0);
      if (wr) chk("data_hwdata", HWDATA, m_rep(wdat, sz));
      for (int i = 0; i < wd; i++) begin
        HREADY = 1'b0; HRESP = rsp;
        nxt(); #1;
        chk("wait_done", mem_done, 1'b0);
        chk("wait_htrans", HTRANS, 2'b00);
        if (wr) chk("wait_hwdata", HWDATA, m_rep(wdat, sz));
      end
      HREADY = 1'b1; HRESP = rsp; HRDATA = rdat;
      nxt();
      HRESP = 1'b0; HRDATA = $urandom;
      #1;
      if (!wr && !rsp) begin
        m_rdata = m_load(rdat, a, sz);
        m_rsize = sz;
      end
      chk("resp_done", mem_done, 1'b1);
      chk("resp_err", mem_err, rsp);
      chk("resp_htrans", HTRANS, 2'b00);
      chk("resp_rdata", r_mem_data, m_rdata);
      chk("resp_rsize", r_size, m_rsize);
      chk("resp_busy", mem_busy, hold);
    end
  endtask

  initial begin
    bit wr, rsp, hold;
    logic [2:0] sz;
    logic [31:0] a;
    reset = 1'b1; mem_req = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_size = '0;
    w_mem_data = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hsize", HSIZE, 3'h0);
    chk("rst_hwrite", HWRITE, 1'b0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_busy", mem_busy, 1'b0);
    chk("rst_done", mem_done, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    chk("rst_rdata", r_mem_data, 32'h0);
    chk("rst_rsize", r_size, 3'h0);
    reset = 1'b0;
    nxt();

    // Zero-wait byte load from the top lane.
    run_txn(0, 32'h1003, 3'd0, 32'h0, 32'hAB00_0000, 0, 0, 0, 0);
    chk("byte_load_value", r_mem_data, 32'h0000_00AB);
    nxt();
    // Halfword store with two data-phase wait states.
    run_txn(1, 32'h2002, 3'd1, 32'h0000_1234, 32'h0, 0, 2, 0, 0);
    nxt();
    // Misaligned word load.
    run_txn(0, 32'h3001, 3'd2, 32'h0, 32'h0, 0, 0, 0, 0);
    nxt();
    // Error response (one HREADY=0 error cycle first).
    run_txn(0, 32'h4000, 3'd2, 32'h0, 32'h5555_AAAA, 0, 1, 1, 0);
    chk("err_keeps_rdata", r_mem_data, 32'h0000_00AB);
    nxt();
    // Back-to-back word loads with mem_req held.
    run_txn(0, 32'h0100, 3'd2, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1);
    run_txn(0, 32'h0104, 3'd2, 32'h0, 32'h00C0_FFEE, 0, 0, 0, 0);
    chk("b2b_second", r_mem_data, 32'h00C0_FFEE);
    nxt();

    // Reset during the data phase aborts with no completion.
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h40; mem_size = 3'd2;
    nxt();
    mem_req = 1'b0; HREADY = 1'b1;
    nxt();
    HREADY = 1'b0; reset = 1'b1;
    nxt();
    reset = 1'b0; HREADY = 1'b1;
    m_rdata = 32'h0; m_rsize = 3'h0;
    #1;
    chk("abort_htrans", HTRANS, 2'b00);
    chk("abort_busy", mem_busy, 1'b0);
    chk("abort_done", mem_done, 1'b0);
    chk("abort_rdata", r_mem_data, m_rdata);
    nxt(); #1;
    chk("abort_done_after", mem_done, 1'b0);
    chk("abort_htrans_after", HTRANS, 2'b00);

    // Randomized traffic.
    hold = 1'b0;
    for (int n = 0; n < 80; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      rsp = ($urandom_range(0, 7) == 0);
      if (!hold && $urandom_range(0, 1) == 1) begin
        nxt(); #1;
        chk("idle_busy", mem_busy, 1'b0);
        chk("idle_htrans", HTRANS, 2'b00);
        chk("idle_done", mem_done, 1'b0);
      end
      hold = (n != 79) && ($urandom_range(0, 2) == 0);
      run_txn(wr, a, sz, $urandom, $urandom, $urandom_range(0, 2),
              $urandom_range(0, 2), rsp, hold);
    end
    mem_req = 1'b0;
    nxt(); #1;
    chk("final_idle_busy", mem_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_mem_access.md
AHB_MEM_ACCESS -- requirements
Module: ahb_mem_access

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge, all state) first, then reset input 1.
REQ-002 SHALL have the following CPU-side ports:
- mem_req input 1: load/store request.
- mem_write input 1: 1=store, 0=load.
- mem_addr input 32: byte address.
- mem_size input 3: HSIZE encoding, 000=8bit, 001=16bit, 010=32bit.
- w_mem_data input 32: store data, right-aligned.
REQ-003 SHALL have the following status and result ports:
- mem_busy output 1: transfer in flight; the pipeline stalls on it.
- mem_done output 1: one-cycle completion pulse.
- mem_err output 1: one-cycle error pulse, coincident with mem_done.
- r_mem_data output 32: load data, right-aligned, upper bits zero; feeds the extend stage.
- r_size output 3: HSIZE of the completed load, for the extend stage.
REQ-004 SHALL have the following AHB-Lite master ports:
- HADDR output 32; HSIZE output 3; HTRANS output 2 (00 IDLE, 10 NONSEQ); HWRITE output 1; HWDATA output 32.
- HRDATA input 32; HREADY input 1; HRESP input 1.

Function
REQ-005 SHALL implement the states IDLE, ADDR, DATA and RESP, with one transfer outstanding at a time.
REQ-006 SHALL accept a request in IDLE or RESP when mem_req=1, registering addr, size, write and wdata.
REQ-007 SHALL treat the following requests as illegal: mem_size > 010, a halfword with addr[0]=1, or a word with addr[1:0]!=00.
REQ-008 SHALL NOT issue a bus transfer for an illegal request; it SHALL go directly to RESP with mem_err=1.
REQ-009 SHALL go from acceptance of a legal request to ADDR; in ADDR it SHALL drive HTRANS=NONSEQ and HADDR/HSIZE/HWRITE from the registered values.
REQ-010 SHALL leave ADDR for DATA on HREADY=1, and SHALL hold all address-phase outputs stable while HREADY=0.
REQ-011 SHALL drive HTRANS=IDLE in DATA, and SHALL drive HWDATA from the registered store data with lane replication:
- byte: {4{b}}
- halfword: {2{h}}
- word: unchanged.
REQ-012 SHALL, in DATA with HREADY=1, capture the lane-aligned HRDATA and go to RESP.
- mem_err SHALL equal HRESP.
- For a store, or when HRESP=1, r_mem_data SHALL be left unchanged.
REQ-013 SHALL select load lanes as follows:
- byte: HRDATA[8*a+7:8*a], a=addr[1:0].
- halfword: HRDATA[31:16] when addr[1]=1, else HRDATA[15:0].
- Result zero-extended to 32 bits; sign extension is not this block's job.
REQ-014 SHALL, while in DATA with HREADY=0, wait indefinitely; an HRESP=1 first error cycle SHALL cause no action.
REQ-015 SHALL assert mem_done=1 only in RESP, for one cycle; RESP SHALL go to IDLE, or directly to ADDR on a legal back-to-back mem_req.
REQ-016 SHALL assert mem_busy=1 in ADDR and DATA and on the accept cycle (mem_req=1 in IDLE or RESP), and mem_busy=0 otherwise.
REQ-017 SHALL hold r_mem_data and r_size stable from RESP until the next load completes.
REQ-018 SHALL, with zero wait states, complete a load accepted at cycle N with mem_done at cycle N+3.
REQ-019 SHALL drive HTRANS=IDLE in every state other than ADDR.

Reset
REQ-020 SHALL, while reset=1 at a clk edge, enter IDLE, regardless of any request or transfer mid-flight.
REQ-021 SHALL produce the following output values in reset:
- HTRANS=00, HADDR=0, HSIZE=000, HWRITE=0, HWDATA=0.
- mem_busy=0, mem_done=0, mem_err=0.
- r_mem_data=0, r_size=000.
REQ-022 SHALL NOT produce a mem_done pulse for a transfer aborted by reset.

Structure
REQ-023 SHALL place the HSIZE codes, the HTRANS codes and the state encoding in a shared package, also used by the extend stage.
REQ-024 SHALL place the lane select/replication logic in one combinational sub-module, ahb_lane_align.

Verification
REQ-025 SHALL cover a zero-wait byte load: addr=0x1003, HRDATA=0xAB000000 -> mem_done at N+3, r_mem_data=0x000000AB, r_size=000.
REQ-026 SHALL cover a halfword store: addr=0x2002, wdata=0x1234, 2 wait states -> HWDATA=0x12341234 held, mem_done at N+5, mem_err=0.
REQ-027 SHALL cover a misaligned word load: addr=0x3001 -> HTRANS stays 00, mem_done=mem_err=1 at N+1.
REQ-028 SHALL cover an error response: HRESP=1,HREADY=0 then HRESP=1,HREADY=1 -> mem_err=1, r_mem_data unchanged.
REQ-029 SHALL cover back-to-back word loads with mem_req held: second HTRANS=NONSEQ in the cycle after the first RESP, with data 0xDEADBEEF then 0x00C0FFEE.
REQ-030 SHALL cover reset asserted in DATA: next cycle IDLE, HTRANS=00, mem_busy=0, no mem_done.
